// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage and a DMA master,
// with CPU priority and a starvation counter that forces the DMA port in after MAX_WAIT refusals.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {S_CPU, S_DMA, S_ACK} state_t;
  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);
  state_t state, state_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic cpu_active, dma_own;
  assign cpu_active = cpu_read || cpu_write;
  assign dma_own    = state == S_DMA;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_CPU;
      wait_cnt  <= '0;
      dma_rdata <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (dma_own && !dma_we) dma_rdata <= mem_rdata;
    end
  end
  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    unique case (state)
      S_CPU: begin
        if (dma_req && (!cpu_active || wait_cnt == MAX_W)) begin
          state_nx = S_DMA;
          wait_nx  = '0;
        end else begin
          wait_nx = dma_req ? wait_cnt + 8'd1 : '0;
        end
      end
      S_DMA:   state_nx = S_ACK;
      default: state_nx = S_CPU;
    endcase
  end
  assign mem_addr  = dma_own ? dma_addr  : cpu_addr;
  assign mem_wdata = dma_own ? dma_wdata : cpu_wdata;
  assign mem_write = dma_own ? dma_we    : cpu_write;
  assign mem_read  = dma_own ? !dma_we   : cpu_read;
  assign cpu_rdata = dma_own ? '0        : mem_rdata;
  assign cpu_stall = dma_own && cpu_active;
  assign dma_ack   = state == S_ACK;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a word-level memory
// model and a grant-timing model derived from the refusal-count rule.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;
  logic        clk = 0, reset;
  logic        cpu_read, cpu_write, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_ack, mem_read, mem_write;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_dr, dwd, cwd;
  int          n_tests = 0, n_fail = 0;
  int          phase, refused, act, ci, di;
  bit          dwe, done, held;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_read = 0; cpu_write = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    reset = 1; cpu_read = 0; cpu_write = 0; cpu_addr = 32'h4; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    repeat (2) cyc();
    #4;
    chk("rst_ack", dma_ack, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_drd", dma_rdata, 0);
    chk("rst_maddr", mem_addr, 32'h4);
    cyc(); reset = 0;

    // CPU write then read, no DMA
    cyc(); cpu_write = 1; cpu_addr = 32'h10; cpu_wdata = 32'h1234_5678;
    #4; chk("cw_mwr", mem_write, 1); chk("cw_stall", cpu_stall, 0);
    cyc(); cpu_write = 0; cpu_read = 1;
    #4; chk("cr_data", cpu_rdata, 32'h1234_5678); chk("cr_stall", cpu_stall, 0); chk("cr_ack", dma_ack, 0);

    // DMA write with CPU idle: S_DMA next cycle, ack two cycles after request
    cyc(); cpu_idle(); dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hCAFE_0001;
    #4; chk("dw0_mwr", mem_write, 0); chk("dw0_ack", dma_ack, 0);
    cyc();
    #4; chk("dw1_mwr", mem_write, 1); chk("dw1_maddr", mem_addr, 32'h20); chk("dw1_ack", dma_ack, 0);
    cyc();
    #4; chk("dw2_ack", dma_ack, 1);
    cyc(); dma_req = 0; cpu_read = 1; cpu_addr = 32'h20;
    #4; chk("dw_rb", cpu_rdata, 32'hCAFE_0001); chk("dw_ack_done", dma_ack, 0);

    // CPU busy every cycle: DMA read forced in after MAX_WAIT refusals
    for (int k = 0; k <= MAX_WAIT + 3; k++) begin
      cyc(); cpu_read = 1; cpu_addr = 32'h10;
      if (k == 0) begin dma_req = 1; dma_we = 0; dma_addr = 32'h10; end
      if (k == MAX_WAIT + 2) dma_req = 0;
      #4;
      chk($sformatf("busy_stall%0d", k), cpu_stall, k == MAX_WAIT + 1);
      chk($sformatf("busy_ack%0d", k), dma_ack, k == MAX_WAIT + 2);
      chk($sformatf("busy_rd%0d", k), cpu_rdata, (k == MAX_WAIT + 1) ? 0 : 32'h1234_5678);
      if (k == MAX_WAIT + 2) chk("busy_drd", dma_rdata, 32'h1234_5678);
    end

    // dma_req held through ack with CPU idle: one access every 3 cycles
    for (int k = 0; k < 9; k++) begin
      cyc(); cpu_idle(); dma_req = 1; dma_we = 0; dma_addr = 32'h20;
      #4;
      chk($sformatf("burst_mrd%0d", k), mem_read, k % 3 == 1);
      chk($sformatf("burst_ack%0d", k), dma_ack, k % 3 == 2);
    end
    cyc(); dma_req = 0;
    chk("burst_drd", dma_rdata, 32'hCAFE_0001);

    // reset asserted during a DMA write to 0x30
    cyc(); dma_req = 1; dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'hDEAD_BEEF;
    cyc();
    #1 reset = 1;
    #3; chk("rdma_mwr", mem_write, 0); chk("rdma_ack", dma_ack, 0);
    cyc(); dma_req = 0; reset = 0;
    #4; chk("rdma_ack2", dma_ack, 0); chk("rdma_drd", dma_rdata, 0); chk("rdma_mwr2", mem_write, 0);
    cyc(); cpu_read = 1; cpu_addr = 32'h30;
    #4; chk("rdma_mem", cpu_rdata, 0);

    // CPU read of 0x40 collides with S_DMA
    cyc(); cpu_read = 0; cpu_write = 1; cpu_addr = 32'h40; cpu_wdata = 32'hA5A5_0040;
    cyc(); cpu_idle(); dma_req = 1; dma_we = 1; dma_addr = 32'h44; dma_wdata = 32'h0000_0044;
    cyc(); cpu_read = 1; cpu_addr = 32'h40;
    #4; chk("col_stall", cpu_stall, 1); chk("col_rd0", cpu_rdata, 0);
    cyc(); dma_req = 0;
    #4; chk("col_stall2", cpu_stall, 0); chk("col_rd", cpu_rdata, 32'hA5A5_0040); chk("col_ack", dma_ack, 1);

    // randomized traffic in 0x200..0x23C against the reference model
    exp_dr = 0;
    cyc(); cpu_idle();
    for (int t = 0; t < 30; t++) begin
      dwe = 1'($urandom_range(0, 1)); di = $urandom_range(0, 15); dwd = $urandom;
      phase = 0; refused = 0; done = 0; held = 0;
      for (int c = 0; c < 20 && !done; c++) begin
        cyc();
        dma_req = 1; dma_we = dwe; dma_addr = 32'h200 + 32'(di << 2); dma_wdata = dwd;
        if (!held) begin act = $urandom_range(0, 2); ci = $urandom_range(0, 15); cwd = $urandom; end
        cpu_read = act == 1; cpu_write = act == 2;
        cpu_addr = 32'h200 + 32'(ci << 2); cpu_wdata = cwd;
        #4;
        chk("r_stall", cpu_stall, phase == 1 && act != 0);
        chk("r_ack", dma_ack, phase == 2);
        if (phase == 1) chk("r_rd0", cpu_rdata, 0);
        else if (act == 1) chk("r_rd", cpu_rdata, ref_mem[ci]);
        if (phase == 2) chk("r_drd", dma_rdata, exp_dr);
        held = phase == 1 && act != 0;
        if (phase != 1 && act == 2) ref_mem[ci] = cwd;
        if (phase == 1) begin
          if (dwe) ref_mem[di] = dwd;
          else exp_dr = ref_mem[di];
        end
        if (phase == 0) begin
          if (act == 0 || refused == MAX_WAIT) phase = 1;
          else refused++;
        end else if (phase == 1) phase = 2;
        else done = 1;
      end
      chk("r_bound", 32'(done), 1);
      if ($urandom_range(0, 1) == 1) begin
        cyc(); dma_req = 0; cpu_idle();
      end
    end
    cyc(); dma_req = 0; cpu_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
